// File: rtl/bot_port_master.sv
// Port-bus initiator for manual rojobot drive: services bot update interrupts, snapshots LocX/LocY/BotInfo/Sensors, writes MotCtl.
// Optional macro BOT_PORT_MASTER_DIGIT_MIRROR_EN appends nibble writes of LocX/LocY to ports 0x03..0x06.
module bot_port_master #(
    parameter logic [2:0]  MAN_SPEED   = 3'd7,
    parameter int unsigned WDOG_CYCLES = 66_000_000
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       enable,
    input  logic [3:0] btns,
    input  logic       interrupt,
    output logic       interrupt_ack,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    output logic [7:0] loc_x,
    output logic [7:0] loc_y,
    output logic [7:0] bot_info,
    output logic [7:0] sensors,
    output logic       snap_valid,
    output logic       wdog_timeout,
    output logic       busy
);
    localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, ACK, RD_X, RD_Y, RD_INFO, RD_SENS, CALC, WR_MOT, WR_LED, WDOG_WR
`ifdef BOT_PORT_MASTER_DIGIT_MIRROR_EN
        , WR_DIG0, WR_DIG1, WR_DIG2, WR_DIG3
`endif
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_GAP} phase_t;

    state_t           state, state_next, bus_follow;
    phase_t           phase, phase_next;
    logic [CNT_W-1:0] wdog_cnt;
    logic             wdog_hit;
    logic [7:0]       tmp_x, tmp_y, tmp_info;
    logic [7:0]       mot_ctl, mot_calc;
    logic [7:0]       bus_addr, bus_data;
    logic             bus_wr;

    assign wdog_hit = (wdog_cnt == WDOG_LAST);
    assign busy     = (state != IDLE);

    // btns = {L, U, R, D}; priority U > D > L > R, dir bit 1 = forward
    always_comb begin
        mot_calc = 8'h00;
        if (btns[2])      mot_calc = {1'b1, MAN_SPEED, 1'b1, MAN_SPEED};
        else if (btns[0]) mot_calc = {1'b0, MAN_SPEED, 1'b0, MAN_SPEED};
        else if (btns[3]) mot_calc = {1'b0, MAN_SPEED, 1'b1, MAN_SPEED};
        else if (btns[1]) mot_calc = {1'b1, MAN_SPEED, 1'b0, MAN_SPEED};
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        interrupt_ack = 1'b0;
        snap_valid    = 1'b0;
        port_id       = 8'h00;
        out_port      = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        bus_addr      = 8'h00;
        bus_data      = 8'h00;
        bus_wr        = 1'b0;
        bus_follow    = IDLE;

        case (state)
            RD_X:    begin bus_addr = 8'h0A; bus_follow = RD_Y;    end
            RD_Y:    begin bus_addr = 8'h0B; bus_follow = RD_INFO; end
            RD_INFO: begin bus_addr = 8'h0C; bus_follow = RD_SENS; end
            RD_SENS: begin bus_addr = 8'h0D; bus_follow = CALC;    end
            WR_MOT:  begin bus_addr = 8'h09; bus_data = mot_ctl; bus_wr = 1'b1; bus_follow = WR_LED; end
`ifdef BOT_PORT_MASTER_DIGIT_MIRROR_EN
            WR_LED:  begin bus_addr = 8'h02; bus_data = sensors; bus_wr = 1'b1; bus_follow = WR_DIG0; end
            WR_DIG0: begin bus_addr = 8'h03; bus_data = {4'h0, loc_x[7:4]}; bus_wr = 1'b1; bus_follow = WR_DIG1; end
            WR_DIG1: begin bus_addr = 8'h04; bus_data = {4'h0, loc_x[3:0]}; bus_wr = 1'b1; bus_follow = WR_DIG2; end
            WR_DIG2: begin bus_addr = 8'h05; bus_data = {4'h0, loc_y[7:4]}; bus_wr = 1'b1; bus_follow = WR_DIG3; end
            WR_DIG3: begin bus_addr = 8'h06; bus_data = {4'h0, loc_y[3:0]}; bus_wr = 1'b1; bus_follow = IDLE;    end
`else
            WR_LED:  begin bus_addr = 8'h02; bus_data = sensors; bus_wr = 1'b1; bus_follow = IDLE; end
`endif
            WDOG_WR: begin bus_addr = 8'h09; bus_data = 8'h00; bus_wr = 1'b1; bus_follow = IDLE; end
            default: ;
        endcase

        case (state)
            IDLE: begin
                if (enable && interrupt)     state_next = ACK;
                else if (enable && wdog_hit) state_next = WDOG_WR;
            end
            ACK: begin
                interrupt_ack = 1'b1;
                state_next    = enable ? RD_X : IDLE;
            end
            CALC: begin
                snap_valid = 1'b1;
                state_next = enable ? WR_MOT : IDLE;
            end
            default: begin
                // SETUP -> STROBE -> GAP; enable is only sampled at the end of the gap
                case (phase)
                    PH_SETUP: begin
                        port_id    = bus_addr;
                        out_port   = bus_wr ? bus_data : 8'h00;
                        phase_next = PH_STROBE;
                    end
                    PH_STROBE: begin
                        port_id      = bus_addr;
                        out_port     = bus_wr ? bus_data : 8'h00;
                        write_strobe = bus_wr;
                        read_strobe  = ~bus_wr;
                        phase_next   = PH_GAP;
                    end
                    default: begin
                        phase_next = PH_SETUP;
                        state_next = enable ? bus_follow : IDLE;
                    end
                endcase
            end
        endcase
    end

    // NOTE: bus outputs decode from state only, so the async reset drops strobes without waiting for a clock.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state        <= IDLE;
            phase        <= PH_SETUP;
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
            tmp_x        <= 8'h00;
            tmp_y        <= 8'h00;
            tmp_info     <= 8'h00;
            loc_x        <= 8'h00;
            loc_y        <= 8'h00;
            bot_info     <= 8'h00;
            sensors      <= 8'h00;
            mot_ctl      <= 8'h00;
        end else begin
            state <= state_next;
            phase <= phase_next;

            // an expiry during a running sequence is simply dropped; its own WR_MOT follows
            if (!enable || state_next == ACK || wdog_hit) wdog_cnt <= '0;
            else                                          wdog_cnt <= wdog_cnt + CNT_W'(1);

            if (state == IDLE && state_next == WDOG_WR) wdog_timeout <= 1'b1;
            else if (state_next == CALC)                wdog_timeout <= 1'b0;

            if (phase == PH_STROBE) begin
                case (state)
                    RD_X:    tmp_x    <= in_port;
                    RD_Y:    tmp_y    <= in_port;
                    RD_INFO: tmp_info <= in_port;
                    RD_SENS: begin
                        loc_x    <= tmp_x;
                        loc_y    <= tmp_y;
                        bot_info <= tmp_info;
                        sensors  <= in_port;
                    end
                    default: ;
                endcase
            end

            if (state == CALC) mot_ctl <= mot_calc;
        end
    end

endmodule
